// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types, widths and opcode helpers
//   WORD / REG_SIZE : datapath and register-index widths
//   alu_op_t        : execute-stage operation code
//   md_state_t      : mul/div unit FSM state
//   em_t            : E/M pipeline register contents
//   is_muldiv()     : true for ops served by the iterative unit
`ifndef WORD
`define WORD 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

package pipeline_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    typedef struct packed {
        logic [`WORD-1:0]     write_data;
        logic [`WORD-1:0]     alu_result;
        logic [`WORD-1:0]     pc;
        logic [`REG_SIZE-1:0] write_reg;
        logic                 reg_write;
        logic                 mem_write;
        logic                 mem2reg;
        logic                 zero;
        logic                 branch;
        logic                 finish;
        logic                 valid;
    } em_t;

    function automatic logic is_muldiv(alu_op_t op);
        return (op == ALU_MUL) || (op == ALU_MULHU) ||
               (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/flopr.sv
// rtl/flopr.sv - resettable register
//   clk, reset : clock, synchronous active-high reset (clears to 0)
//   d, q       : WIDTH-bit data in / registered data out
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative unsigned multiply / divide unit
//   clk, reset     : clock, synchronous active-high reset
//   start          : valid multi-cycle op presented (sampled in IDLE)
//   op, a, b       : operation and operands, held stable while busy
//   kill           : abandon any operation and return to IDLE
//   busy           : combinational stall request
//   done           : high in the DONE cycle; result is valid then
//   result         : selected word of the product / quotient / remainder
module muldiv_iter
    import pipeline_pkg::*;
#(
    parameter int MD_STEPS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [`WORD-1:0] a,
    input  logic [`WORD-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [`WORD-1:0] result
);

    localparam int W  = `WORD;
    localparam int CW = (MD_STEPS > 1) ? $clog2(MD_STEPS) : 1;

    md_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    alu_op_t         r_op;
    // r_hi / r_lo hold {partial product, multiplier} for MUL*,
    // and {remainder, quotient} for DIV*/REM*.
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic [W-1:0]    r_b;

    logic            w_is_mul;
    logic [W-1:0]    w_addend;
    logic [W:0]      w_sum;
    logic [W:0]      w_shift;
    logic            w_ge;
    logic [W:0]      w_diff;
    logic [W-1:0]    w_hi_nxt;
    logic [W-1:0]    w_lo_nxt;

    assign w_is_mul = (r_op == ALU_MUL) || (r_op == ALU_MULHU);

    // Shift-add multiply step: add b when the multiplier LSB is set,
    // then shift the whole {carry, hi, lo} right by one.
    assign w_addend = r_lo[0] ? r_b : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};

    // Restoring divide step: bring the next dividend bit into the
    // remainder, subtract when it fits. b == 0 always "fits", which
    // naturally yields quotient all-ones and remainder == a.
    assign w_shift  = {r_hi, r_lo[W-1]};
    assign w_ge     = (w_shift >= {1'b0, r_b});
    assign w_diff   = w_shift - {1'b0, r_b};

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (w_is_mul) begin
            w_hi_nxt = w_sum[W:1];
            w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
        end else begin
            w_hi_nxt = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
            w_lo_nxt = {r_lo[W-2:0], w_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_op    <= ALU_ADD;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
        end else if (kill) begin
            r_state <= MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_b     <= b;
                        r_hi    <= '0;
                        r_lo    <= a;
                        r_cnt   <= '0;
                        r_state <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(MD_STEPS - 1)) r_state <= MD_DONE;
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign busy = ((r_state == MD_IDLE) && start) || (r_state == MD_RUN);
    assign done = (r_state == MD_DONE);

    always_comb begin
        result = '0;
        case (r_op)
            ALU_MUL, ALU_DIVU:   result = r_lo;
            ALU_MULHU, ALU_REMU: result = r_hi;
            default:             result = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// rtl/execute.sv - execute stage: single-cycle ALU, iterative mul/div, E/M register
//   clk, reset        : clock, synchronous active-high reset
//   srcAE, srcBE      : operands; shift amount is srcBE[4:0]
//   writeDataE, pcE   : passed through to M
//   writeRegE         : destination register
//   aluControlE       : operation code
//   regWriteE..validE : control bits
//   flushE            : kill the instruction in execute
//   *M outputs        : E/M pipeline register
//   busyE             : combinational stall request to the hazard unit
module execute
    import pipeline_pkg::*;
#(
    parameter int MD_STEPS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [`WORD-1:0]     srcAE,
    input  logic [`WORD-1:0]     srcBE,
    input  logic [`WORD-1:0]     writeDataE,
    input  logic [`WORD-1:0]     pcE,
    input  logic [`REG_SIZE-1:0] writeRegE,
    input  alu_op_t              aluControlE,
    input  logic                 regWriteE,
    input  logic                 memWriteE,
    input  logic                 mem2regE,
    input  logic                 branchE,
    input  logic                 finishE,
    input  logic                 validE,
    input  logic                 flushE,
    output logic [`WORD-1:0]     writeDataM,
    output logic [`WORD-1:0]     ALUResultM,
    output logic [`WORD-1:0]     pcM,
    output logic [`REG_SIZE-1:0] writeRegM,
    output logic                 regWriteM,
    output logic                 memWriteM,
    output logic                 mem2regM,
    output logic                 zeroM,
    output logic                 branchM,
    output logic                 finishM,
    output logic                 validM,
    output logic                 busyE
);

    localparam int W = `WORD;

    logic          w_is_md;
    logic          w_md_start;
    logic          w_md_busy;
    logic          w_md_done;
    logic [W-1:0]  w_md_result;
    logic [4:0]    w_shamt;
    logic [W-1:0]  w_alu_result;
    logic [W-1:0]  w_result;
    logic          w_bubble;
    em_t           w_em_d;
    em_t           w_em_q;

    assign w_is_md    = is_muldiv(aluControlE);
    assign w_md_start = validE && w_is_md;
    assign w_shamt    = srcBE[4:0];

    muldiv_iter #(
        .MD_STEPS (MD_STEPS)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_md_start),
        .op     (aluControlE),
        .a      (srcAE),
        .b      (srcBE),
        .kill   (flushE),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result)
    );

    assign busyE = w_md_busy;

    always_comb begin
        w_alu_result = '0;
        case (aluControlE)
            ALU_ADD:  w_alu_result = srcAE + srcBE;
            ALU_SUB:  w_alu_result = srcAE - srcBE;
            ALU_AND:  w_alu_result = srcAE & srcBE;
            ALU_OR:   w_alu_result = srcAE | srcBE;
            ALU_XOR:  w_alu_result = srcAE ^ srcBE;
            ALU_SLT:  w_alu_result = {{(W-1){1'b0}}, ($signed(srcAE) < $signed(srcBE))};
            ALU_SLTU: w_alu_result = {{(W-1){1'b0}}, (srcAE < srcBE)};
            ALU_SLL:  w_alu_result = srcAE << w_shamt;
            ALU_SRL:  w_alu_result = srcAE >> w_shamt;
            ALU_SRA:  w_alu_result = $signed(srcAE) >>> w_shamt;
            default:  w_alu_result = '0;
        endcase
    end

    assign w_result = w_is_md ? w_md_result : w_alu_result;

    // A mul/div opcode only carries a real result in its DONE cycle; any
    // other slot holding one (e.g. validE = 0) goes downstream as a bubble.
    assign w_bubble = busyE || flushE || (w_is_md && !w_md_done);

    always_comb begin
        w_em_d = '0;
        if (!w_bubble) begin
            w_em_d.write_data = writeDataE;
            w_em_d.alu_result = w_result;
            w_em_d.pc         = pcE;
            w_em_d.write_reg  = writeRegE;
            w_em_d.reg_write  = regWriteE;
            w_em_d.mem_write  = memWriteE;
            w_em_d.mem2reg    = mem2regE;
            w_em_d.zero       = (w_result == '0);
            w_em_d.branch     = branchE;
            w_em_d.finish     = finishE;
            w_em_d.valid      = validE;
        end
    end

    flopr #(
        .WIDTH ($bits(em_t))
    ) u_em_reg (
        .clk   (clk),
        .reset (reset),
        .d     (w_em_d),
        .q     (w_em_q)
    );

    assign writeDataM = w_em_q.write_data;
    assign ALUResultM = w_em_q.alu_result;
    assign pcM        = w_em_q.pc;
    assign writeRegM  = w_em_q.write_reg;
    assign regWriteM  = w_em_q.reg_write;
    assign memWriteM  = w_em_q.mem_write;
    assign mem2regM   = w_em_q.mem2reg;
    assign zeroM      = w_em_q.zero;
    assign branchM    = w_em_q.branch;
    assign finishM    = w_em_q.finish;
    assign validM     = w_em_q.valid;

endmodule
